// File: rtl/jtcop_gfx_slot_pkg.sv
// -----------------------------------------------------------------------------
// jtcop_pkg
//   Shared types and constants for the BAC06 tile-layer fetch slot
//   (jtcop_gfx_slot) and its 2-entry cache (jtcop_gfx_cache).
//   - state_t       : slot FSM state, also exported on the slot debug port
//   - CACHE_ENTRIES : number of cache lines (one LRU bit selects the victim)
//   - entry_bits()  : width of one packed {valid, tag, word} cache line
// -----------------------------------------------------------------------------
package jtcop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int CACHE_ENTRIES = 2;

  function automatic int entry_bits(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/jtcop_gfx_slot_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces around jtcop_gfx_slot.
//
// Handshake semantics:
//   Client side (jtcop_gfx_if): the video block holds cs=1 with an address;
//   the slot answers combinationally with ok=1 and data whenever that address
//   is cached. There is no ready: the client keeps asking until ok is seen.
//   SDRAM side (jtcop_sdram_if): sdram_req is a level held together with a
//   stable sdram_addr until the controller returns sdram_ack=1 for one cycle.
//   The word then arrives with a one-cycle sdram_rdy pulse on sdram_din
//   (possibly in the same cycle as the ack).
//
// jtcop_gfx_if  : cs, addr (master->slave); data, ok (slave->master)
// jtcop_sdram_if: sdram_req, sdram_addr (master->slave);
//                 sdram_ack, sdram_rdy, sdram_din (slave->master)
// -----------------------------------------------------------------------------
interface jtcop_gfx_if #(
  parameter int AW = 19,
  parameter int DW = 32
);
  logic          cs;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ok;

  modport master (output cs, output addr, input  data, input  ok);
  modport slave  (input  cs, input  addr, output data, output ok);
endinterface

interface jtcop_sdram_if #(
  parameter int SDW = 22,
  parameter int DW  = 32
);
  logic           sdram_req;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           sdram_rdy;
  logic [DW-1:0]  sdram_din;

  modport master (output sdram_req, output sdram_addr,
                  input  sdram_ack, input  sdram_rdy, input sdram_din);
  modport slave  (input  sdram_req, input  sdram_addr,
                  output sdram_ack, output sdram_rdy, output sdram_din);
endinterface

// File: rtl/jtcop_gfx_cache.sv
// -----------------------------------------------------------------------------
// jtcop_gfx_cache
//   Two-entry fully associative tag/data store with a single LRU bit.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     inv                 : clears both valid bits; also masks hit this cycle
//     cs, addr            : lookup request
//     fill_en/tag/data    : write {1, tag, data} into the LRU victim entry
//     hit, hit_data       : combinational lookup result (data=0 on no hit)
//     lru_dbg             : current victim pointer
// -----------------------------------------------------------------------------
module jtcop_gfx_cache
  import jtcop_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inv,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  output logic          lru_dbg
);

  logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
  logic [AW-1:0]            tag_q  [CACHE_ENTRIES];
  logic [AW-1:0]            tag_d  [CACHE_ENTRIES];
  logic [DW-1:0]            word_q [CACHE_ENTRIES];
  logic [DW-1:0]            word_d [CACHE_ENTRIES];
  logic                     lru_q, lru_d;
  logic                     match0, match1;

  always_comb begin
    match0   = valid_q[0] && (tag_q[0] == addr);
    match1   = valid_q[1] && (tag_q[1] == addr);
    // inv kills the valid bits this cycle, so the answer must drop now too
    hit      = cs && !inv && (match0 || match1);
    hit_data = '0;
    if (hit) hit_data = match0 ? word_q[0] : word_q[1];
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    lru_d   = lru_q;
    if (fill_en) begin
      valid_d[lru_q] = 1'b1;
      tag_d[lru_q]   = fill_tag;
      word_d[lru_q]  = fill_data;
      lru_d          = ~lru_q;
    end else if (hit) begin
      // the entry just used becomes most recent; the other one is the victim
      lru_d = match0 ? 1'b1 : 1'b0;
    end
    if (inv) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      word_q  <= '{default: '0};
      lru_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
      lru_q   <= lru_d;
    end
  end

  assign lru_dbg = lru_q;

endmodule

// File: rtl/jtcop_gfx_slot.sv
// -----------------------------------------------------------------------------
// jtcop_gfx_slot
//   Memory-side responder for one BAC06 tile-layer fetch port. Lookups are
//   answered from a 2-entry cache; a miss issues one SDRAM read at
//   OFFSET+addr and fills the cache when the word returns.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     inv      : one-cycle cache invalidate (ROM download / CPU write)
//     gfx      : client bus (cs, addr -> data, ok), slave side
//     sdram    : SDRAM controller slot (req, addr -> ack, rdy, din), master
//     st_dbg   : current FSM state
// -----------------------------------------------------------------------------
module jtcop_gfx_slot
  import jtcop_pkg::*;
#(
  parameter int             AW     = 19,
  parameter int             DW     = 32,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inv,
  jtcop_gfx_if.slave      gfx,
  jtcop_sdram_if.master   sdram,
  output state_t          st_dbg
);

  state_t         state_q, state_d;
  logic           sdram_req_q, sdram_req_d;
  logic [SDW-1:0] sdram_addr_q, sdram_addr_d;
  logic [AW-1:0]  req_addr_q, req_addr_d;
  logic           fill_kill_q, fill_kill_d;
  logic           fill_rdy;
  logic           fill_en;
  logic           hit;
  logic [DW-1:0]  hit_data;
  logic           lru_unused;

  jtcop_gfx_cache #(
    .AW (AW),
    .DW (DW)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .inv       (inv),
    .cs        (gfx.cs),
    .addr      (gfx.addr),
    .fill_en   (fill_en),
    .fill_tag  (req_addr_q),
    .fill_data (sdram.sdram_din),
    .hit       (hit),
    .hit_data  (hit_data),
    .lru_dbg   (lru_unused)
  );

  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    req_addr_d   = req_addr_q;
    fill_kill_d  = fill_kill_q;
    fill_rdy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gfx.cs && !hit) begin
          // zero-extend then add; the sum wraps modulo 2^SDW
          sdram_addr_d = OFFSET + SDW'(gfx.addr);
          req_addr_d   = gfx.addr;
          sdram_req_d  = 1'b1;
          fill_kill_d  = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (sdram.sdram_ack) begin
          sdram_req_d = 1'b0;
          if (sdram.sdram_rdy) begin
            fill_rdy = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram.sdram_rdy) begin
          fill_rdy = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // an invalidate while a read is outstanding makes that data stale
    if (inv && state_q != IDLE) fill_kill_d = 1'b1;
  end

  // inv in the fill cycle also blocks the write (and the LRU toggle)
  assign fill_en = fill_rdy && !fill_kill_q && !inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      req_addr_q   <= '0;
      fill_kill_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      req_addr_q   <= req_addr_d;
      fill_kill_q  <= fill_kill_d;
    end
  end

  assign gfx.ok           = hit;
  assign gfx.data         = hit_data;
  assign sdram.sdram_req  = sdram_req_q;
  assign sdram.sdram_addr = sdram_addr_q;
  assign st_dbg           = state_q;

endmodule

// File: tb/tb_jtcop_gfx_slot.sv
// -----------------------------------------------------------------------------
// tb_jtcop_gfx_slot
//   Directed bench for jtcop_gfx_slot: a main instance at OFFSET=0 and a
//   second instance at OFFSET=22'h3FFFF0 for the address wrap case. Inputs
//   are driven 1 time unit after the rising edge, outputs sampled 2 units
//   after it.
// -----------------------------------------------------------------------------
module tb_jtcop_gfx_slot;
  import jtcop_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic inv;
  logic inv_w;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  jtcop_gfx_if   #(.AW(19),  .DW(32)) gfx ();
  jtcop_sdram_if #(.SDW(22), .DW(32)) sd ();
  jtcop_gfx_if   #(.AW(19),  .DW(32)) gfx_w ();
  jtcop_sdram_if #(.SDW(22), .DW(32)) sd_w ();
  state_t st;
  state_t st_w;

  jtcop_gfx_slot #(.AW(19), .DW(32), .SDW(22), .OFFSET(22'h0)) dut (
    .clk    (clk),
    .rst    (rst),
    .inv    (inv),
    .gfx    (gfx),
    .sdram  (sd),
    .st_dbg (st)
  );

  jtcop_gfx_slot #(.AW(19), .DW(32), .SDW(22), .OFFSET(22'h3FFFF0)) dut_wrap (
    .clk    (clk),
    .rst    (rst),
    .inv    (inv_w),
    .gfx    (gfx_w),
    .sdram  (sd_w),
    .st_dbg (st_w)
  );

  // ---------------- request counter (rising edges of sdram_req) ----------------
  int   req_cnt = 0;
  logic req_prev = 1'b0;
  always @(posedge clk) begin
    if (sd.sdram_req && !req_prev) req_cnt <= req_cnt + 1;
    req_prev <= sd.sdram_req;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!sd.sdram_req && n < 20) begin
      tick();
      settle();
      n++;
    end
    chk(tag, 64'(sd.sdram_req), 64'd1);
  endtask

  // ack one cycle after req is seen; ends in WAIT with req dropped
  task automatic do_ack();
    tick();
    chk("req_held", 64'(sd.sdram_req), 64'd1);
    sd.sdram_ack = 1'b1;
    tick();
    sd.sdram_ack = 1'b0;
    settle();
    chk("req_drop", 64'(sd.sdram_req), 64'd0);
    chk("st_wait", 64'(st), 64'(WAIT));
  endtask

  // rdy two cycles after the ack, one-cycle pulse
  task automatic do_rdy(input logic [31:0] d);
    tick();
    sd.sdram_rdy = 1'b1;
    sd.sdram_din = d;
    settle();
    chk("ok_low_at_rdy", 64'(gfx.ok), 64'd0);
    tick();
    sd.sdram_rdy = 1'b0;
    sd.sdram_din = '0;
    settle();
  endtask

  task automatic miss_fetch(input logic [18:0] a, input logic [31:0] d,
                            input logic [21:0] exp_sa);
    gfx.cs   = 1'b1;
    gfx.addr = a;
    settle();
    chk("miss_ok0", 64'(gfx.ok), 64'd0);
    wait_req("miss_req");
    chk("miss_sdram_addr", 64'(sd.sdram_addr), 64'(exp_sa));
    do_ack();
    exp_q.push_back(d);
    do_rdy(d);
    chk("fill_ok", 64'(gfx.ok), 64'd1);
    chk("fill_data", 64'(gfx.data), 64'(exp_q.pop_front()));
  endtask

  task automatic expect_hit(input logic [18:0] a, input logic [31:0] d);
    gfx.cs   = 1'b1;
    gfx.addr = a;
    settle();
    chk("hit_ok", 64'(gfx.ok), 64'd1);
    chk("hit_data", 64'(gfx.data), 64'(d));
  endtask

  // ---------------- directed sequence ----------------
  int rc;

  initial begin
    rst = 1'b1; inv = 1'b0; inv_w = 1'b0;
    gfx.cs = 1'b0;   gfx.addr = '0;
    sd.sdram_ack = 1'b0; sd.sdram_rdy = 1'b0; sd.sdram_din = '0;
    gfx_w.cs = 1'b0; gfx_w.addr = '0;
    sd_w.sdram_ack = 1'b0; sd_w.sdram_rdy = 1'b0; sd_w.sdram_din = '0;
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_ok", 64'(gfx.ok), 64'd0);
    chk("rst_data", 64'(gfx.data), 64'd0);
    chk("rst_req", 64'(sd.sdram_req), 64'd0);
    chk("rst_sdram_addr", 64'(sd.sdram_addr), 64'd0);
    chk("rst_state", 64'(st), 64'(IDLE));

    // first miss, single request
    rc = req_cnt;
    miss_fetch(19'h00010, 32'hDEADBEEF, 22'h00010);
    chk("single_req_10", 64'(req_cnt - rc), 64'd1);

    // second miss, then re-present 10 as a hit with no new request
    miss_fetch(19'h00020, 32'hCAFEF00D, 22'h00020);
    rc = req_cnt;
    expect_hit(19'h00010, 32'hDEADBEEF);
    expect_hit(19'h00020, 32'hCAFEF00D);
    tick(); tick(); settle();
    chk("hit_no_req", 64'(sd.sdram_req), 64'd0);
    chk("hit_no_req_cnt", 64'(req_cnt - rc), 64'd0);

    // 20 was used last, so 30 evicts 10
    miss_fetch(19'h00030, 32'h30303030, 22'h00030);
    expect_hit(19'h00020, 32'hCAFEF00D);
    rc = req_cnt;
    miss_fetch(19'h00010, 32'h11111111, 22'h00010);
    chk("refetch_10", 64'(req_cnt - rc), 64'd1);

    // address change during WAIT: 10 still filled, then one request for 40
    gfx.cs = 1'b0;
    inv = 1'b1;
    tick();
    inv = 1'b0;
    rc = req_cnt;
    gfx.cs = 1'b1; gfx.addr = 19'h00010;
    settle();
    wait_req("chg_req10");
    chk("chg_addr10", 64'(sd.sdram_addr), 64'h10);
    do_ack();
    gfx.addr = 19'h00040;
    do_rdy(32'hA0A0A0A0);
    wait_req("chg_req40");
    chk("chg_addr40", 64'(sd.sdram_addr), 64'h40);
    do_ack();
    chk("chg_req_cnt", 64'(req_cnt - rc), 64'd2);
    do_rdy(32'h40404040);
    chk("chg_ok40", 64'(gfx.ok), 64'd1);
    chk("chg_data40", 64'(gfx.data), 64'h40404040);
    expect_hit(19'h00010, 32'hA0A0A0A0);
    tick(); tick(); settle();
    chk("chg_no_dup", 64'(req_cnt - rc), 64'd2);

    // inv drops ok in the same cycle
    inv = 1'b1;
    settle();
    chk("inv_ok_drop", 64'(gfx.ok), 64'd0);
    tick();
    inv = 1'b0;
    settle();
    chk("inv_invalid", 64'(gfx.ok), 64'd0);

    // inv during WAIT discards the fill; same addr is requested again
    rc = req_cnt;
    wait_req("invw_req");
    do_ack();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    do_rdy(32'hBAD0BAD0);
    chk("invw_discard", 64'(gfx.ok), 64'd0);
    wait_req("invw_rereq");
    chk("invw_addr", 64'(sd.sdram_addr), 64'h10);
    do_ack();
    chk("invw_req_cnt", 64'(req_cnt - rc), 64'd2);
    do_rdy(32'h10101010);
    chk("invw_ok", 64'(gfx.ok), 64'd1);
    chk("invw_data", 64'(gfx.data), 64'h10101010);

    // inv in the same cycle as the fill: entry stays invalid
    gfx.addr = 19'h00090;
    settle();
    wait_req("invf_req");
    do_ack();
    tick();
    sd.sdram_rdy = 1'b1; sd.sdram_din = 32'h90909090; inv = 1'b1;
    tick();
    sd.sdram_rdy = 1'b0; sd.sdram_din = '0; inv = 1'b0;
    settle();
    chk("invf_ok", 64'(gfx.ok), 64'd0);
    wait_req("invf_rereq");
    do_ack();
    do_rdy(32'h99999999);
    chk("invf_data", 64'(gfx.data), 64'h99999999);

    // reset during REQ, then a stray rdy
    gfx.addr = 19'h00070;
    settle();
    wait_req("rst_req70");
    rst = 1'b1;
    gfx.cs = 1'b0;
    tick();
    settle();
    chk("midrst_req", 64'(sd.sdram_req), 64'd0);
    chk("midrst_ok", 64'(gfx.ok), 64'd0);
    chk("midrst_state", 64'(st), 64'(IDLE));
    rst = 1'b0;
    sd.sdram_rdy = 1'b1; sd.sdram_din = 32'h77777777;
    tick();
    sd.sdram_rdy = 1'b0; sd.sdram_din = '0;
    settle();
    chk("stray_state", 64'(st), 64'(IDLE));
    gfx.cs = 1'b1; gfx.addr = 19'h00070;
    settle();
    chk("stray_no_fill", 64'(gfx.ok), 64'd0);

    // ack and rdy together in REQ: direct fill
    wait_req("both_req");
    tick();
    sd.sdram_ack = 1'b1; sd.sdram_rdy = 1'b1; sd.sdram_din = 32'h70707070;
    tick();
    sd.sdram_ack = 1'b0; sd.sdram_rdy = 1'b0; sd.sdram_din = '0;
    settle();
    chk("both_ok", 64'(gfx.ok), 64'd1);
    chk("both_data", 64'(gfx.data), 64'h70707070);
    chk("both_state", 64'(st), 64'(IDLE));
    chk("both_req_low", 64'(sd.sdram_req), 64'd0);

    // OFFSET + addr wraps modulo 2^22
    gfx_w.cs = 1'b1; gfx_w.addr = 19'h00020;
    tick();
    settle();
    chk("wrap_addr", 64'(sd_w.sdram_addr), 64'h000010);
    chk("wrap_req", 64'(sd_w.sdram_req), 64'd1);
    chk("wrap_state", 64'(st_w), 64'(REQ));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
